sprite_cmd_tx: RTL and testbench

SPRITE_CMD_TX -- requirements
Module: sprite_cmd_tx

---
 rtl/sprite_cmd_tx.sv | 127 ++++++++++++
 tb/tb_sprite_cmd_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_cmd_tx.sv
// Serializes one sprite update request into write/command/data register-bus beats.
// Define SPRITE_CMD_SKIP_UNCHANGED_EN to send only fields that differ from the last value sent.
module sprite_cmd_tx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_enable,
  input  logic [9:0] req_x1,
  input  logic [9:0] req_x2,
  input  logic [8:0] req_y1,
  input  logic [8:0] req_y2,
  input  logic [2:0] req_color,
  output logic       write,
  output logic [3:0] command,
  output logic [9:0] data,
  output logic       busy
);

  typedef struct packed {
    logic       enable;
    logic [9:0] x1;
    logic [9:0] x2;
    logic [8:0] y1;
    logic [8:0] y2;
    logic [2:0] color;
  } sprite_req_t;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
  localparam int NF = 6;
  // Field index 0..5 maps to x1, y1, x2, y2, color, enable; enable last so visibility flips after geometry.
  localparam logic [NF-1:0][3:0] FIELD_CMD = {4'd1, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};

  logic [0:0]  state;
  logic [2:0]  idx;
  sprite_req_t hold, req_in, src;
  logic [NF-1:0][9:0] src_data;
  logic [NF-1:0] diff;
  logic [2:0]  start, nxt;
  logic        found, handshake, emit_beat;

  assign req_in    = '{enable: req_enable, x1: req_x1, x2: req_x2,
                       y1: req_y1, y2: req_y2, color: req_color};
  assign req_ready = (state == S_IDLE) && reset_n;
  assign busy      = (state == S_EMIT);
  assign handshake = req_valid && req_ready;

  // In IDLE the first beat comes straight from the inputs so it lands the cycle after the handshake.
  assign src   = (state == S_IDLE) ? req_in : hold;
  assign start = (state == S_IDLE) ? 3'd0 : idx + 3'd1;

  assign src_data[0] = src.x1;
  assign src_data[1] = {1'b0, src.y1};
  assign src_data[2] = src.x2;
  assign src_data[3] = {1'b0, src.y2};
  assign src_data[4] = {7'b0, src.color};
  assign src_data[5] = {9'b0, src.enable};

`ifdef SPRITE_CMD_SKIP_UNCHANGED_EN
  logic [NF-1:0][9:0] shadow;

  always_comb begin
    diff = '0;
    for (int i = 0; i < NF; i++) diff[i] = (src_data[i] != shadow[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow[0] <= 10'd0;
      shadow[1] <= 10'd0;
      shadow[2] <= 10'd100;
      shadow[3] <= 10'd100;
      shadow[4] <= 10'd7;
      shadow[5] <= 10'd1;
    end else if (emit_beat) begin
      shadow[nxt] <= src_data[nxt];
    end
  end
`else
  assign diff = '1;
`endif

  always_comb begin
    found = 1'b0;
    nxt   = 3'd0;
    for (int i = 0; i < NF; i++) begin
      if (!found && i >= int'(start) && diff[i]) begin
        found = 1'b1;
        nxt   = 3'(i);
      end
    end
  end

  assign emit_beat = found && ((state == S_EMIT) || handshake);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      hold    <= '0;
      write   <= 1'b0;
      command <= 4'd0;
      data    <= 10'd0;
    end else begin
      write   <= 1'b0;
      command <= 4'd0;
      data    <= 10'd0;
      if (emit_beat) begin
        write   <= 1'b1;
        command <= FIELD_CMD[nxt];
        data    <= src_data[nxt];
        idx     <= nxt;
      end
      case (state)
        S_IDLE: if (handshake) begin
          hold  <= req_in;
          state <= S_EMIT;
          // Nothing to send: park on the last index so EMIT lasts exactly one cycle.
          if (!found) idx <= 3'd5;
        end
        default: if (!found) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_cmd_tx.sv
// Directed self-checking bench for sprite_cmd_tx; outputs sampled on the falling edge.
module tb_sprite_cmd_tx;
  logic       clk = 1'b0;
  logic       reset_n, req_valid, req_ready, req_enable;
  logic [9:0] req_x1, req_x2;
  logic [8:0] req_y1, req_y2;
  logic [2:0] req_color;
  logic       write, busy;
  logic [3:0] command;
  logic [9:0] data;

  int n_run = 0;
  int n_fail = 0;
  logic [3:0] ecmd[6];
  logic [9:0] edat[6];

  always #5 clk = ~clk;

  sprite_cmd_tx dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_enable(req_enable), .req_x1(req_x1), .req_x2(req_x2), .req_y1(req_y1),
    .req_y2(req_y2), .req_color(req_color), .write(write), .command(command),
    .data(data), .busy(busy)
  );

  task automatic drive_req(input logic en, input logic [9:0] x1, input logic [8:0] y1,
                           input logic [9:0] x2, input logic [8:0] y2, input logic [2:0] c);
    req_enable = en; req_x1 = x1; req_y1 = y1; req_x2 = x2; req_y2 = y2; req_color = c;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b1;
    drive_req(1'b1, 10'd1, 9'd2, 10'd3, 9'd4, 3'd5);
    @(posedge clk); @(negedge clk);
    n_run++;
    if ({write, command, data} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got w=%0b cmd=%0d data=%0h, want 0", write, command, data);
    end
    n_run++;
    if ({req_ready, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_busy: got rdy=%0b busy=%0b, want 0 0", req_ready, busy);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_basic;
    reset_n = 1'b1; req_valid = 1'b1;
    drive_req(1'b1, 10'd5, 9'd6, 10'd300, 9'd200, 3'd3);
    #1;
    n_run++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL first_ready: got %0b want 1", req_ready);
    end
    ecmd = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    edat = '{10'd5, 10'd6, 10'd300, 10'd200, 10'd3, 10'd1};
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin req_valid = 1'b0; drive_req(1'b0, 10'd1023, 9'd511, 10'd0, 9'd0, 3'd0); end
      n_run++;
      if ({write, command, data, busy, req_ready} !== {1'b1, ecmd[k], edat[k], 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL basic_beat%0d: got w=%0b cmd=%0d data=%0d busy=%0b rdy=%0b, want cmd=%0d data=%0d",
                           k, write, command, data, busy, req_ready, ecmd[k], edat[k]);
      end
    end
    @(negedge clk);
    n_run++;
    if ({write, command, data, busy, req_ready} !== {15'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_end: got w=%0b cmd=%0d data=%0d busy=%0b rdy=%0b, want idle rdy=1",
                         write, command, data, busy, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1;
    drive_req(1'b0, 10'd10, 9'd20, 10'd30, 9'd40, 3'd1);
    ecmd = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    edat = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd1, 10'd0};
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0 || k == 4) drive_req(1'b1, 10'd11, 9'd21, 10'd31, 9'd41, 3'd2);
      if (k == 2) drive_req(1'b0, 10'd999, 9'd499, 10'd777, 9'd333, 3'd5);
      n_run++;
      if (k < 6) begin
        if ({write, command, data, req_ready} !== {1'b1, ecmd[k], edat[k], 1'b0}) begin
          n_fail++; $display("FAIL b2b_first_beat%0d: got w=%0b cmd=%0d data=%0d rdy=%0b, want cmd=%0d data=%0d",
                             k, write, command, data, req_ready, ecmd[k], edat[k]);
        end
      end else if ({write, req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL b2b_gap: got w=%0b rdy=%0b, want w=0 rdy=1", write, req_ready);
      end
    end
    edat = '{10'd11, 10'd21, 10'd31, 10'd41, 10'd2, 10'd1};
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin req_valid = 1'b0; drive_req(1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 3'd0); end
      n_run++;
      if ({write, command, data} !== {1'b1, ecmd[k], edat[k]}) begin
        n_fail++; $display("FAIL b2b_second_beat%0d: got w=%0b cmd=%0d data=%0d, want cmd=%0d data=%0d",
                           k, write, command, data, ecmd[k], edat[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    req_valid = 1'b1;
    drive_req(1'b1, 10'd100, 9'd101, 10'd102, 9'd103, 3'd4);
    ecmd = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    edat = '{10'd100, 10'd101, 10'd102, 10'd103, 10'd4, 10'd1};
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      n_run++;
      if ({write, command, data} !== {1'b1, ecmd[k], edat[k]}) begin
        n_fail++; $display("FAIL abort_beat%0d: got w=%0b cmd=%0d data=%0d, want cmd=%0d data=%0d",
                           k, write, command, data, ecmd[k], edat[k]);
      end
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_run++;
    if ({write, command, data, busy, req_ready} !== 17'd0) begin
      n_fail++; $display("FAIL abort_reset: got w=%0b cmd=%0d data=%0d busy=%0b rdy=%0b, want all 0",
                         write, command, data, busy, req_ready);
    end
    reset_n = 1'b1;
    #1;
    n_run++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_release_ready: got %0b want 1", req_ready);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_run++;
      if ({write, busy} !== 2'b00) begin
        n_fail++; $display("FAIL abort_quiet%0d: got w=%0b busy=%0b, want 0 0", k, write, busy);
      end
    end
  endtask

  task automatic test_zero_ext;
    req_valid = 1'b1;
    drive_req(1'b0, 10'd0, 9'd511, 10'd1023, 9'd0, 3'd7);
    ecmd = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    edat = '{10'h000, 10'h1FF, 10'h3FF, 10'h000, 10'h007, 10'h000};
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      n_run++;
      if ({write, command, data} !== {1'b1, ecmd[k], edat[k]}) begin
        n_fail++; $display("FAIL zext_beat%0d: got w=%0b cmd=%0d data=%03h, want cmd=%0d data=%03h",
                           k, write, command, data, ecmd[k], edat[k]);
      end
    end
    @(negedge clk);
  endtask

`ifdef SPRITE_CMD_SKIP_UNCHANGED_EN
  task automatic test_skip;
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1; req_valid = 1'b1;
    drive_req(1'b1, 10'd0, 9'd0, 10'd150, 9'd100, 3'd7);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_run++;
    if ({write, command, data, busy} !== {1'b1, 4'd4, 10'd150, 1'b1}) begin
      n_fail++; $display("FAIL skip_single: got w=%0b cmd=%0d data=%0d busy=%0b, want 1 4 150 1", write, command, data, busy);
    end
    @(negedge clk);
    n_run++;
    if ({write, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL skip_single_end: got w=%0b busy=%0b rdy=%0b, want 0 0 1", write, busy, req_ready);
    end
    req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_run++;
    if ({write, busy} !== 2'b01) begin
      n_fail++; $display("FAIL skip_none_busy: got w=%0b busy=%0b, want 0 1", write, busy);
    end
    @(negedge clk);
    n_run++;
    if ({write, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL skip_none_end: got w=%0b busy=%0b rdy=%0b, want 0 0 1", write, busy, req_ready);
    end
  endtask
`else
  task automatic test_defaults_all_beats;
    req_valid = 1'b1;
    drive_req(1'b1, 10'd0, 9'd0, 10'd100, 9'd100, 3'd7);
    ecmd = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    edat = '{10'd0, 10'd0, 10'd100, 10'd100, 10'd7, 10'd1};
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      n_run++;
      if ({write, command, data} !== {1'b1, ecmd[k], edat[k]}) begin
        n_fail++; $display("FAIL defaults_beat%0d: got w=%0b cmd=%0d data=%0d, want cmd=%0d data=%0d",
                           k, write, command, data, ecmd[k], edat[k]);
      end
    end
    @(negedge clk);
    n_run++;
    if ({write, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL defaults_end: got w=%0b busy=%0b rdy=%0b, want 0 0 1", write, busy, req_ready);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; req_valid = 1'b0;
    drive_req(1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 3'd0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_abort();
    test_zero_ext();
`ifdef SPRITE_CMD_SKIP_UNCHANGED_EN
    test_skip();
`else
    test_defaults_all_beats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
